// File: rtl/ka_encode_dat.sv
// ka_encode_dat -- transmit-side packer for the KA data word.
//
// Gathers one control word plus SLICES slice addresses. The addresses arrive
// one per beat. The packer emits them as a single frame with a valid/ready
// handshake. Frame layout matches the KA decode stage:
//   t_ka_dat = {ctrl[SELOU-1:0], slice[SLICES-1], ..., slice[0]}
// so slice k sits at bits [k*BADDR +: BADDR].
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   i_ctrl                control word, captured only on the slot-0 beat
//   i_addr                slice address for the current slot
//   i_valid / i_ready     input beat handshake
//   t_ka_dat              packed frame
//   t_ka_valid/t_ka_ready frame handshake
//   o_busy                registered, high while a partial frame is gathered
//   i_flush               level request to close a partial frame
//                         (present only with KA_ENC_FLUSH_EN defined)
//
// Optional feature macro: KA_ENC_FLUSH_EN (adds i_flush).

module ka_encode_dat #(
  parameter int SELOU  = 8,
  parameter int SLICES = 4,
  parameter int BADDR  = 10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [SELOU-1:0]              i_ctrl,
  input  logic [BADDR-1:0]              i_addr,
  input  logic                          i_valid,
  output logic                          i_ready,
`ifdef KA_ENC_FLUSH_EN
  input  logic                          i_flush,
`endif
  output logic [SELOU+SLICES*BADDR-1:0] t_ka_dat,
  output logic                          t_ka_valid,
  input  logic                          t_ka_ready,
  output logic                          o_busy
);

  localparam int            CW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  logic [CW-1:0]                cnt, cnt_nx;
  logic [SELOU-1:0]             ctrl_q, ctrl_nx;
  logic [SLICES-1:0][BADDR-1:0] slc_q, slc_nx;
  logic                         last, load_ok, acc, fl, load;

  assign last    = (cnt == LAST);
  assign load_ok = !t_ka_valid || t_ka_ready;
  // Only the beat that completes a frame must wait for the output register.
  assign i_ready = !last || load_ok;
  assign acc     = i_valid && i_ready;

`ifdef KA_ENC_FLUSH_EN
  // A flush only closes a frame that has started and only when the output can
  // take it. Otherwise the request stays pending because the source holds it.
  assign fl = i_flush && (cnt != '0) && load_ok;
`else
  assign fl = 1'b0;
`endif

  assign load = (acc && last) || fl;

  // Next gather contents. A slot-0 beat starts a fresh frame. It takes the
  // control word and clears the higher slices, so a flushed frame has zeros
  // in every slice it did not fill.
  always_comb begin
    ctrl_nx = ctrl_q;
    slc_nx  = slc_q;
    if (acc) begin
      if (cnt == '0) begin
        ctrl_nx = i_ctrl;
        slc_nx  = '0;
      end
      for (int k = 0; k < SLICES; k++)
        if (cnt == CW'(k)) slc_nx[k] = i_addr;
    end
  end

  always_comb begin
    cnt_nx = cnt;
    if (load)     cnt_nx = '0;
    else if (acc) cnt_nx = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      ctrl_q     <= '0;
      slc_q      <= '0;
      t_ka_dat   <= '0;
      t_ka_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      o_busy <= (cnt_nx != '0);
      if (acc) begin
        ctrl_q <= ctrl_nx;
        slc_q  <= slc_nx;
      end
      // The output takes the merged gather value, so the completing beat's
      // address lands in the frame at this same edge.
      if (load) begin
        t_ka_dat   <= {ctrl_nx, slc_nx};
        t_ka_valid <= 1'b1;
      end else if (t_ka_ready) begin
        t_ka_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ka_encode_dat.sv
// Bench for ka_encode_dat. Main instance: SELOU=8, SLICES=4, BADDR=10.
// A second instance with SLICES=1 covers the single-slice build.
module tb_ka_encode_dat;
  localparam int SELOU = 8, SLICES = 4, BADDR = 10;
  localparam int FW = SELOU + SLICES * BADDR;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [7:0]    i_ctrl = '0;
  logic [9:0]    i_addr = '0;
  logic          i_valid = 1'b0, i_ready;
  logic [FW-1:0] t_ka_dat;
  logic          t_ka_valid, t_ka_ready, o_busy;
  logic [1:0]    rdy_mode = 2'd1;   // 0 stall, 1 always ready, 2 random
  logic          rnd_rdy = 1'b0;
`ifdef KA_ENC_FLUSH_EN
  logic          i_flush = 1'b0;
`endif

  logic [7:0]    c1 = '0;
  logic [9:0]    a1 = '0;
  logic          v1 = 1'b0, r1, tv1, busy1;
  logic [17:0]   d1;

  assign t_ka_ready = (rdy_mode == 2'd2) ? rnd_rdy : rdy_mode[0];

  always #5 clk = ~clk;
  always @(posedge clk) begin #1; rnd_rdy = 1'($urandom_range(0, 1)); end

  ka_encode_dat #(.SELOU(SELOU), .SLICES(SLICES), .BADDR(BADDR)) u_dut (
    .clk(clk), .reset_n(reset_n), .i_ctrl(i_ctrl), .i_addr(i_addr),
    .i_valid(i_valid), .i_ready(i_ready),
`ifdef KA_ENC_FLUSH_EN
    .i_flush(i_flush),
`endif
    .t_ka_dat(t_ka_dat), .t_ka_valid(t_ka_valid), .t_ka_ready(t_ka_ready),
    .o_busy(o_busy));

  ka_encode_dat #(.SELOU(8), .SLICES(1), .BADDR(10)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .i_ctrl(c1), .i_addr(a1),
    .i_valid(v1), .i_ready(r1),
`ifdef KA_ENC_FLUSH_EN
    .i_flush(1'b0),
`endif
    .t_ka_dat(d1), .t_ka_valid(tv1), .t_ka_ready(1'b1), .o_busy(busy1));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a list of beats in the current frame. It turns into a
  // frame value with shifts, and finished frames go into a queue.
  logic [FW-1:0] exp_q[$];
  int            nbeat = 0;
  logic [7:0]    m_ctrl = '0;
  logic [9:0]    m_addr[SLICES];

  function automatic logic [FW-1:0] build();
    logic [FW-1:0] f = FW'(m_ctrl);
    for (int k = SLICES - 1; k >= 0; k--) f = (f << BADDR) | FW'(m_addr[k]);
    return f;
  endfunction

  task automatic model_beat(input logic [7:0] c, input logic [9:0] a);
    if (nbeat == 0) begin
      m_ctrl = c;
      for (int k = 0; k < SLICES; k++) m_addr[k] = '0;
    end
    m_addr[nbeat] = a;
    nbeat++;
    if (nbeat == SLICES) begin
      exp_q.push_back(build());
      nbeat = 0;
    end
  endtask

  task automatic model_flush();
    if (nbeat != 0) begin
      exp_q.push_back(build());
      nbeat = 0;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs from posedge+1 and returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [7:0] c, input logic [9:0] a, input int gap);
    bit ok = 1'b0;
    repeat (gap) step();
    i_ctrl = c; i_addr = a; i_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (i_ready) begin
        ok = 1'b1;
        model_beat(c, a);
      end
      step();
    end
    i_valid = 1'b0;
    chk("beat_accept", 64'(ok), 64'd1);
  endtask

  // Output monitor: checks every handshaken frame against the model queue
  // and checks that a stalled frame stays stable.
  logic          prev_stall = 1'b0;
  logic [FW-1:0] prev_dat = '0;
  always @(negedge clk) begin
    if (!reset_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(t_ka_valid), 64'd1);
        chk("hold_dat", 64'(t_ka_dat), 64'(prev_dat));
      end
      if (t_ka_valid && t_ka_ready) begin
        chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("frame_dat", 64'(t_ka_dat), 64'(exp_q.pop_front()));
      end
      prev_stall = t_ka_valid && !t_ka_ready;
      prev_dat   = t_ka_dat;
    end
  end

  localparam logic [FW-1:0] F_T1 = {8'hA5, 10'h004, 10'h003, 10'h002, 10'h001};
  localparam logic [FW-1:0] F_B1 = {8'h5A, 10'h104, 10'h103, 10'h102, 10'h101};
  localparam logic [FW-1:0] F_B2 = {8'hC3, 10'h204, 10'h203, 10'h202, 10'h201};

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(t_ka_valid), 64'd0);
    chk("rst_dat", 64'(t_ka_dat), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_irdy", 64'(i_ready), 64'd1);
    step(); reset_n = 1'b1; step();

    // 1. Basic frame
    rdy_mode = 2'd1;
    for (int k = 1; k <= 4; k++) send(8'hA5, 10'(k), 0);
    @(negedge clk);
    chk("t1_valid", 64'(t_ka_valid), 64'd1);
    chk("t1_dat", 64'(t_ka_dat), 64'(F_T1));
    step(); @(negedge clk);
    chk("t1_valid_drop", 64'(t_ka_valid), 64'd0);
    step();

    // 2. Backpressure
    rdy_mode = 2'd0;
    for (int k = 1; k <= 4; k++) send(8'h5A, 10'(12'h100 + k), 0);
    send(8'hC3, 10'h201, 0); send(8'hC3, 10'h202, 0); send(8'hC3, 10'h203, 0);
    i_ctrl = 8'hC3; i_addr = 10'h204; i_valid = 1'b1;
    @(negedge clk);
    chk("t2_stall_irdy", 64'(i_ready), 64'd0);
    chk("t2_hold_f1", 64'(t_ka_dat), 64'(F_B1));
    step(); @(negedge clk);
    chk("t2_stall_irdy2", 64'(i_ready), 64'd0);
    chk("t2_busy", 64'(o_busy), 64'd1);
    step(); rdy_mode = 2'd1;
    @(negedge clk);
    chk("t2_release_irdy", 64'(i_ready), 64'd1);
    model_beat(8'hC3, 10'h204);
    step(); i_valid = 1'b0;
    @(negedge clk);
    chk("t2_f2_valid", 64'(t_ka_valid), 64'd1);
    chk("t2_f2_dat", 64'(t_ka_dat), 64'(F_B2));
    step(); step();

    // 3. Control capture on slot 0 only
    send(8'h11, 10'h0AA, 0);
    for (int k = 0; k < 3; k++) send(8'hFF, 10'(k + 5), 0);
    @(negedge clk);
    chk("t3_ctrl", 64'(t_ka_dat[FW-1 -: 8]), 64'h11);
    step(); step();

    // 4. Gaps, then a reset in the middle of a frame
    for (int k = 1; k <= 4; k++) send(8'hA5, 10'(k), $urandom_range(0, 3));
    @(negedge clk);
    chk("t4_gap_dat", 64'(t_ka_dat), 64'(F_T1));
    step(); step();
    send(8'h77, 10'h0F0, 0); send(8'h77, 10'h0F1, 0);
    @(negedge clk);
    chk("t4_busy_mid", 64'(o_busy), 64'd1);
    step(); reset_n = 1'b0; nbeat = 0;
    @(negedge clk);
    chk("t4_rst_valid", 64'(t_ka_valid), 64'd0);
    chk("t4_rst_dat", 64'(t_ka_dat), 64'd0);
    chk("t4_rst_busy", 64'(o_busy), 64'd0);
    step(); reset_n = 1'b1; step();
    for (int k = 1; k <= 4; k++) send(8'hA5, 10'(k), 0);
    @(negedge clk);
    chk("t4_clean_dat", 64'(t_ka_dat), 64'(F_T1));
    step(); step();

`ifdef KA_ENC_FLUSH_EN
    // 5. Flush a partial frame, then a flush with nothing gathered
    send(8'h3C, 10'h011, 0); send(8'h3C, 10'h022, 0);
    i_flush = 1'b1;
    @(negedge clk); model_flush();
    step(); i_flush = 1'b0;
    @(negedge clk);
    chk("t5_valid", 64'(t_ka_valid), 64'd1);
    chk("t5_dat", 64'(t_ka_dat), 64'({8'h3C, 10'h0, 10'h0, 10'h022, 10'h011}));
    chk("t5_busy", 64'(o_busy), 64'd0);
    step(); step(); i_flush = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("t5_idle_flush_valid", 64'(t_ka_valid), 64'd0);
      step();
    end
    i_flush = 1'b0;
`endif

    // 6. SLICES=1 instance
    c1 = 8'h01; a1 = 10'h3FF; v1 = 1'b1;
    @(negedge clk); chk("t6_irdy", 64'(r1), 64'd1);
    step(); c1 = 8'h02; a1 = 10'h155;
    @(negedge clk);
    chk("t6_f1_valid", 64'(tv1), 64'd1);
    chk("t6_f1_dat", 64'(d1), 64'({8'h01, 10'h3FF}));
    step(); v1 = 1'b0;
    @(negedge clk);
    chk("t6_f2_valid", 64'(tv1), 64'd1);
    chk("t6_f2_dat", 64'(d1), 64'({8'h02, 10'h155}));
    chk("t6_busy", 64'(busy1), 64'd0);
    step(); @(negedge clk);
    chk("t6_idle", 64'(tv1), 64'd0);
    step();

    // Random traffic with random downstream readiness
    rdy_mode = 2'd2;
    for (int f = 0; f < 30; f++)
      for (int k = 0; k < SLICES; k++)
        send(8'($urandom), 10'($urandom), $urandom_range(0, 2));
    rdy_mode = 2'd1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) step();
    step(); step();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
